// File: rtl/pwm_compare_deadtime.sv
// pwm_compare_deadtime
// Consumer side of the shared triangle-carrier bus, built once per inverter leg.
// It compares the carrier against a shadow-buffered duty value and drives one
// complementary gate pair with a programmable dead time.
//
// Compile-time option:
//   PWM_DOUBLE_UPDATE_EN - when defined, carrier_high is also a duty update
//                          boundary, so duty can load twice per carrier period.
//                          When undefined, only carrier_low is a boundary.
//
// Gate FSM
//   state        | meaning
//   ST_OFF       | leg disabled, both gates off
//   ST_DT_TO_HI  | dead interval before turning the upper switch on
//   ST_HI        | upper switch on
//   ST_DT_TO_LO  | dead interval before turning the lower switch on
//   ST_LO        | lower switch on
module pwm_compare_deadtime #(
    parameter int CW  = 16,
    parameter int DTW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [CW-1:0]  carrier,
    input  logic           carrier_high,
    input  logic           carrier_low,
    input  logic           enable,
    input  logic [CW-1:0]  duty_in,
    input  logic           duty_valid,
    input  logic [DTW-1:0] deadtime,
    output logic [CW-1:0]  duty_active,
    output logic           update_pulse,
    output logic           gate_hi,
    output logic           gate_lo
);

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_DT_TO_HI = 3'd1,
        ST_HI       = 3'd2,
        ST_DT_TO_LO = 3'd3,
        ST_LO       = 3'd4
    } state_t;

    logic [CW-1:0]  shadow_q, shadow_d;
    logic           pend_q, pend_d;
    logic [CW-1:0]  duty_active_q, duty_active_d;
    logic           update_pulse_q, update_pulse_d;
    logic           ref_q, ref_d;
    state_t         state_q;
    logic [DTW-1:0] dt_cnt_q;
    logic           gate_hi_q, gate_lo_q;
    logic           boundary;

`ifdef PWM_DOUBLE_UPDATE_EN
    // Both carrier extremes are update points.
    assign boundary = carrier_low | carrier_high;
`else
    // Only the carrier valley is an update point; the peak flag is unused.
    logic unused_carrier_high;
    assign unused_carrier_high = carrier_high;
    assign boundary            = carrier_low;
`endif

    // Shadow/active duty handling: a strobe landing on a boundary goes straight
    // to the active register so a stale pending value can never overwrite it.
    always_comb begin
        shadow_d       = shadow_q;
        pend_d         = pend_q;
        duty_active_d  = duty_active_q;
        update_pulse_d = 1'b0;
        if (boundary && duty_valid) begin
            duty_active_d  = duty_in;
            pend_d         = 1'b0;
            update_pulse_d = 1'b1;
        end else if (boundary && pend_q) begin
            duty_active_d  = shadow_q;
            pend_d         = 1'b0;
            update_pulse_d = 1'b1;
        end else if (duty_valid) begin
            shadow_d = duty_in;
            pend_d   = 1'b1;
        end
    end

    // Carrier compare against the duty value in use; full-width unsigned.
    assign ref_d = (carrier < duty_active_q);

    // Duty registers and registered compare result.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q       <= '0;
            pend_q         <= 1'b0;
            duty_active_q  <= '0;
            update_pulse_q <= 1'b0;
            ref_q          <= 1'b0;
        end else begin
            shadow_q       <= shadow_d;
            pend_q         <= pend_d;
            duty_active_q  <= duty_active_d;
            update_pulse_q <= update_pulse_d;
            ref_q          <= ref_d;
        end
    end

    // Gate FSM; gate outputs are registered from the next state so they always
    // match the state they belong to and can never both be high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_OFF;
            dt_cnt_q  <= '0;
            gate_hi_q <= 1'b0;
            gate_lo_q <= 1'b0;
        end else if (!enable) begin
            state_q   <= ST_OFF;
            dt_cnt_q  <= '0;
            gate_hi_q <= 1'b0;
            gate_lo_q <= 1'b0;
        end else begin
            gate_hi_q <= 1'b0;
            gate_lo_q <= 1'b0;
            case (state_q)
                ST_OFF: begin
                    dt_cnt_q <= deadtime;
                    state_q  <= ref_q ? ST_DT_TO_HI : ST_DT_TO_LO;
                end
                ST_HI: begin
                    if (!ref_q) begin
                        state_q  <= ST_DT_TO_LO;
                        dt_cnt_q <= deadtime;
                    end else begin
                        gate_hi_q <= 1'b1;
                    end
                end
                ST_LO: begin
                    if (ref_q) begin
                        state_q  <= ST_DT_TO_HI;
                        dt_cnt_q <= deadtime;
                    end else begin
                        gate_lo_q <= 1'b1;
                    end
                end
                ST_DT_TO_HI: begin
                    // Aborting to LO is safe: both switches are already off.
                    if (!ref_q) begin
                        state_q   <= ST_LO;
                        gate_lo_q <= 1'b1;
                    end else if (dt_cnt_q == '0) begin
                        state_q   <= ST_HI;
                        gate_hi_q <= 1'b1;
                    end else begin
                        dt_cnt_q <= dt_cnt_q - DTW'(1);
                    end
                end
                ST_DT_TO_LO: begin
                    if (ref_q) begin
                        state_q   <= ST_HI;
                        gate_hi_q <= 1'b1;
                    end else if (dt_cnt_q == '0) begin
                        state_q   <= ST_LO;
                        gate_lo_q <= 1'b1;
                    end else begin
                        dt_cnt_q <= dt_cnt_q - DTW'(1);
                    end
                end
                default: begin
                    state_q  <= ST_OFF;
                    dt_cnt_q <= '0;
                end
            endcase
        end
    end

    assign duty_active  = duty_active_q;
    assign update_pulse = update_pulse_q;
    assign gate_hi      = gate_hi_q;
    assign gate_lo      = gate_lo_q;

endmodule

// File: tb/tb_pwm_compare_deadtime.sv
// Bench for pwm_compare_deadtime: a hand-computed vector table, then model-driven
// carrier scenarios scored through an expected-value queue.
module tb_pwm_compare_deadtime;

    localparam int CW  = 16;
    localparam int DTW = 8;
`ifdef PWM_DOUBLE_UPDATE_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    localparam int M_OFF = 0, M_DTH = 1, M_HI = 2, M_DTL = 3, M_LO = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [CW-1:0]  carrier;
    logic           carrier_high, carrier_low, enable;
    logic [CW-1:0]  duty_in;
    logic           duty_valid;
    logic [DTW-1:0] deadtime;
    logic [CW-1:0]  duty_active;
    logic           update_pulse, gate_hi, gate_lo;

    pwm_compare_deadtime #(.CW(CW), .DTW(DTW)) dut (
        .clk(clk), .rst(rst), .carrier(carrier), .carrier_high(carrier_high),
        .carrier_low(carrier_low), .enable(enable), .duty_in(duty_in),
        .duty_valid(duty_valid), .deadtime(deadtime), .duty_active(duty_active),
        .update_pulse(update_pulse), .gate_hi(gate_hi), .gate_lo(gate_lo)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic hi, lo, pulse;
        logic [CW-1:0] duty;
    } exp_t;

    typedef struct {
        logic rst, en;
        logic [CW-1:0] car;
        logic clow;
        logic [CW-1:0] din;
        logic dv;
        logic [DTW-1:0] dt;
        logic ehi, elo;
        logic [CW-1:0] eduty;
        logic epulse;
    } vec_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // reference model state
    logic [CW-1:0]  m_shadow, m_duty;
    logic           m_pend, m_pulse, m_ref;
    int             m_state;
    int             m_dt;

    // carrier generator state
    int cv;
    bit up;
    int cmax;

    function automatic vec_t mk(logic r, logic e, int car, int din, logic dv, int dt,
                                logic ehi, logic elo, int eduty, logic ep);
        vec_t v;
        v.rst = r; v.en = e; v.car = CW'(car); v.clow = (car == 0);
        v.din = CW'(din); v.dv = dv; v.dt = DTW'(dt);
        v.ehi = ehi; v.elo = elo; v.eduty = CW'(eduty); v.epulse = ep;
        return v;
    endfunction

    task automatic model_reset();
        m_shadow = '0; m_duty = '0; m_pend = 0; m_pulse = 0; m_ref = 0;
        m_state = M_OFF; m_dt = 0;
    endtask

    // Computes the values the DUT should show after the coming clock edge.
    task automatic model_step();
        logic bnd, nref;
        bnd  = carrier_low | (DBL & carrier_high);
        nref = (carrier < m_duty);
        if (rst) begin
            model_reset();
        end else begin
            m_pulse = 0;
            if (bnd && duty_valid) begin
                m_duty = duty_in; m_pend = 0; m_pulse = 1;
            end else if (bnd && m_pend) begin
                m_duty = m_shadow; m_pend = 0; m_pulse = 1;
            end else if (duty_valid) begin
                m_shadow = duty_in; m_pend = 1;
            end
            if (!enable) begin
                m_state = M_OFF; m_dt = 0;
            end else begin
                case (m_state)
                    M_OFF: begin m_dt = deadtime; m_state = m_ref ? M_DTH : M_DTL; end
                    M_HI:  if (!m_ref) begin m_state = M_DTL; m_dt = deadtime; end
                    M_LO:  if (m_ref)  begin m_state = M_DTH; m_dt = deadtime; end
                    M_DTH: if (!m_ref) m_state = M_LO;
                           else if (m_dt == 0) m_state = M_HI;
                           else m_dt = m_dt - 1;
                    M_DTL: if (m_ref) m_state = M_HI;
                           else if (m_dt == 0) m_state = M_LO;
                           else m_dt = m_dt - 1;
                    default: m_state = M_OFF;
                endcase
            end
            m_ref = nref;
        end
    endtask

    task automatic check_out(input string name);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: scoreboard queue empty", name, cyc);
        end else begin
            e = exp_q.pop_front();
            if (gate_hi !== e.hi || gate_lo !== e.lo || update_pulse !== e.pulse ||
                duty_active !== e.duty) begin
                n_fail++;
                $display("FAIL %s cyc=%0d: got hi=%b lo=%b pulse=%b duty=%0d, expected hi=%b lo=%b pulse=%b duty=%0d",
                         name, cyc, gate_hi, gate_lo, update_pulse, duty_active,
                         e.hi, e.lo, e.pulse, e.duty);
            end
        end
        n_checks++;
        if ((gate_hi & gate_lo) !== 1'b0) begin
            n_fail++;
            $display("FAIL overlap cyc=%0d: got hi&lo=%b, expected 0", cyc, gate_hi & gate_lo);
        end
    endtask

    // One clock with the pins as currently driven, scored by the model.
    task automatic model_cycle(input string name);
        exp_t e;
        model_step();
        e.hi = (m_state == M_HI); e.lo = (m_state == M_LO);
        e.pulse = m_pulse; e.duty = m_duty;
        exp_q.push_back(e);
        @(posedge clk); #1;
        cyc++;
        check_out(name);
        @(negedge clk);
    endtask

    task automatic drive_carrier();
        carrier      = CW'(cv);
        carrier_low  = (cv == 0);
        carrier_high = (cv == cmax);
    endtask

    task automatic carrier_step();
        if (up) begin cv++; if (cv == cmax) up = 0; end
        else begin cv--; if (cv == 0) up = 1; end
    endtask

    task automatic direct_check(input string name, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    // Runs n carrier cycles with optional mid-ramp strobes; counts gate/pulse activity.
    task automatic run_carrier(input int n, input string name, input bit strobe2,
                               input int d_up, input int d_dn,
                               output int hi_cnt, output int lo_cnt, output int pu_cnt);
        hi_cnt = 0; lo_cnt = 0; pu_cnt = 0;
        for (int i = 0; i < n; i++) begin
            drive_carrier();
            duty_valid = 0;
            if (strobe2 && cv == 50) begin
                duty_valid = 1;
                duty_in    = CW'(up ? d_up : d_dn);
            end
            model_cycle(name);
            hi_cnt += int'(gate_hi);
            lo_cnt += int'(gate_lo);
            pu_cnt += int'(update_pulse);
            carrier_step();
        end
        duty_valid = 0;
    endtask

    vec_t tbl[20];
    int   hc, lc, pc;
    int   ab_hi;

    initial begin
        rst = 1; enable = 0; carrier = '0; carrier_high = 0; carrier_low = 1;
        duty_in = '0; duty_valid = 0; deadtime = '0;

        //           rst en car din dv dt  hi lo duty pulse
        tbl[0]  = mk(1, 0, 50,  0, 0, 0,  0, 0,  0, 0);
        tbl[1]  = mk(1, 1, 50, 30, 1, 4,  0, 0,  0, 0);
        tbl[2]  = mk(1, 1, 50,  0, 0, 4,  0, 0,  0, 0);
        tbl[3]  = mk(0, 1, 50,  0, 0, 4,  0, 0,  0, 0);
        tbl[4]  = mk(0, 1, 50,  0, 0, 1,  0, 0,  0, 0);
        tbl[5]  = mk(0, 1, 50,  0, 0, 1,  0, 0,  0, 0);
        tbl[6]  = mk(0, 1, 50,  0, 0, 1,  0, 0,  0, 0);
        tbl[7]  = mk(0, 1, 50,  0, 0, 1,  0, 0,  0, 0);
        tbl[8]  = mk(0, 1, 50,  0, 0, 1,  0, 1,  0, 0);
        tbl[9]  = mk(0, 1, 50, 70, 1, 1,  0, 1,  0, 0);
        tbl[10] = mk(0, 1, 50,  0, 0, 1,  0, 1,  0, 0);
        tbl[11] = mk(0, 1,  0,  0, 0, 1,  0, 1, 70, 1);
        tbl[12] = mk(0, 1,  0,  0, 0, 1,  0, 1, 70, 0);
        tbl[13] = mk(0, 1, 10,  0, 0, 0,  0, 0, 70, 0);
        tbl[14] = mk(0, 1, 10,  0, 0, 0,  1, 0, 70, 0);
        tbl[15] = mk(0, 1, 20, 60, 1, 0,  1, 0, 70, 0);
        tbl[16] = mk(0, 1,  0, 25, 1, 0,  1, 0, 25, 1);
        tbl[17] = mk(0, 1,  0,  0, 0, 0,  1, 0, 25, 0);
        tbl[18] = mk(0, 0,  0,  0, 0, 0,  0, 0, 25, 0);
        tbl[19] = mk(0, 0, 50,  0, 0, 0,  0, 0, 25, 0);

        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            exp_t e;
            rst = tbl[i].rst; enable = tbl[i].en; carrier = tbl[i].car;
            carrier_low = tbl[i].clow; carrier_high = 1'b0;
            duty_in = tbl[i].din; duty_valid = tbl[i].dv; deadtime = tbl[i].dt;
            e.hi = tbl[i].ehi; e.lo = tbl[i].elo; e.pulse = tbl[i].epulse; e.duty = tbl[i].eduty;
            exp_q.push_back(e);
            @(posedge clk); #1;
            cyc++;
            check_out($sformatf("vec%0d", i));
            @(negedge clk);
        end

        // Model-scored phases start from a fresh reset.
        cmax = 100; cv = 0; up = 1;
        rst = 1; enable = 0; duty_valid = 0; deadtime = 8'd2;
        model_reset();
        for (int i = 0; i < 3; i++) begin drive_carrier(); model_cycle("reset"); end
        rst = 0; enable = 1;

        // Steady PWM, duty 40 loaded by a strobe on the valley.
        drive_carrier(); duty_in = 16'd40; duty_valid = 1;
        model_cycle("load40"); duty_valid = 0; carrier_step();
        run_carrier(400, "settle40", 0, 0, 0, hc, lc, pc);
        run_carrier(200, "steady40", 0, 0, 0, hc, lc, pc);
        direct_check("steady40_hi_cycles", hc, 76);
        direct_check("steady40_lo_cycles", lc, 118);
        direct_check("steady40_pulses", pc, 0);

        // Extremes: duty 0 -> lower switch steady, duty above carrier_max -> upper steady.
        drive_carrier(); duty_in = 16'd0; duty_valid = 1; model_cycle("load0");
        duty_valid = 0; carrier_step();
        run_carrier(400, "settle0", 0, 0, 0, hc, lc, pc);
        run_carrier(200, "duty0", 0, 0, 0, hc, lc, pc);
        direct_check("duty0_lo_cycles", lc, 200);
        direct_check("duty0_hi_cycles", hc, 0);
        drive_carrier(); duty_in = 16'd200; duty_valid = 1; model_cycle("load200");
        duty_valid = 0; carrier_step();
        run_carrier(400, "settle200", 0, 0, 0, hc, lc, pc);
        run_carrier(200, "duty200", 0, 0, 0, hc, lc, pc);
        direct_check("duty200_hi_cycles", hc, 200);
        direct_check("duty200_lo_cycles", lc, 0);

        // Double-strobe per period: one load per period, two with the peak boundary.
        run_carrier(400, "dbl_settle", 1, 30, 60, hc, lc, pc);
        run_carrier(200, "dbl_window", 1, 30, 60, hc, lc, pc);
        direct_check("pulses_per_period", pc, DBL ? 2 : 1);

        // Abort: one-cycle compare glitch while in LO with deadtime 5.
        drive_carrier(); duty_in = 16'd40; duty_valid = 1; model_cycle("load40b");
        duty_valid = 0;
        deadtime = 8'd5;
        carrier = 16'd60; carrier_low = 0; carrier_high = 0;
        for (int i = 0; i < 12; i++) model_cycle("hold_lo");
        ab_hi = 0;
        carrier = 16'd10; model_cycle("glitch");
        ab_hi += int'(gate_hi);
        carrier = 16'd60;
        for (int i = 0; i < 10; i++) begin model_cycle("abort"); ab_hi += int'(gate_hi); end
        direct_check("abort_hi_cycles", ab_hi, 0);
        direct_check("abort_back_lo", int'(gate_lo), 1);

        // Reach HI, then drop enable.
        carrier = 16'd10;
        for (int i = 0; i < 10; i++) model_cycle("to_hi");
        direct_check("reached_hi", int'(gate_hi), 1);
        enable = 0; model_cycle("disable");
        direct_check("disable_hi", int'(gate_hi), 0);
        direct_check("disable_lo", int'(gate_lo), 0);
        model_cycle("disabled");

        direct_check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

endmodule
